// File: rtl/adc_scan_sequencer.sv
// ADC scan sequencer: issues per-channel sample commands over a channel range,
// averages 2^AVG_LOG2 responses per channel and emits one result pulse per
// channel. Supports single and continuous scans with a bounded number of
// commands in flight.
module adc_scan_sequencer #(
  parameter int AVG_LOG2 = 2,
  parameter int MAX_OUT  = 2
) (
  input  logic        clock_clk,
  input  logic        reset_sink_reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic [4:0]  chan_first,
  input  logic [4:0]  chan_last,
  input  logic        cont,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  input  logic        response_startofpacket,
  input  logic        response_endofpacket,
  output logic        result_valid,
  output logic [4:0]  result_channel,
  output logic [11:0] result_data,
  output logic        result_last,
  output logic        busy,
  output logic        seq_err,
  output logic        cfg_err
);

  localparam int             CW       = 5;
  localparam logic [CW-1:0]  CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [1:0]     MAX_OUTL = 2'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [4:0]    first_q, first_d, last_q, last_d;
  logic          cont_q, cont_d, stop_pend_q, stop_pend_d;
  logic [4:0]    iss_ch_q, iss_ch_d, rsp_ch_q, rsp_ch_d;
  logic [CW-1:0] iss_cnt_q, iss_cnt_d, rsp_cnt_q, rsp_cnt_d;
  logic [1:0]    out_q, out_d;
  logic [15:0]   acc_q, acc_d, acc_sum;
  logic          cmd_valid_q, cmd_valid_d;
  logic [4:0]    cmd_channel_q, cmd_channel_d;
  logic          cmd_pkt_q, cmd_pkt_d;
  logic          result_valid_q, result_valid_d, result_last_q, result_last_d;
  logic [4:0]    result_channel_q, result_channel_d;
  logic [11:0]   result_data_q, result_data_d;
  logic          busy_q, busy_d, seq_err_q, seq_err_d, cfg_err_q, cfg_err_d;
  logic          hs, rsp_ok;

  // Packet delimiters on the response side carry no information for us.
  logic unused_rsp_pkt;
  assign unused_rsp_pkt = response_startofpacket ^ response_endofpacket;

  assign command_valid         = cmd_valid_q;
  assign command_channel       = cmd_channel_q;
  assign command_startofpacket = cmd_pkt_q;
  assign command_endofpacket   = cmd_pkt_q;
  assign result_valid          = result_valid_q;
  assign result_channel        = result_channel_q;
  assign result_data           = result_data_q;
  assign result_last           = result_last_q;
  assign busy                  = busy_q;
  assign seq_err               = seq_err_q;
  assign cfg_err               = cfg_err_q;

  // Next-state: issue side, response/averaging side and scan control.
  always_comb begin
    state_d          = state_q;
    first_d          = first_q;
    last_d           = last_q;
    cont_d           = cont_q;
    stop_pend_d      = stop_pend_q;
    iss_ch_d         = iss_ch_q;
    iss_cnt_d        = iss_cnt_q;
    rsp_ch_d         = rsp_ch_q;
    rsp_cnt_d        = rsp_cnt_q;
    acc_d            = acc_q;
    seq_err_d        = seq_err_q;
    cfg_err_d        = 1'b0;
    result_valid_d   = 1'b0;
    result_channel_d = result_channel_q;
    result_data_d    = result_data_q;
    result_last_d    = result_last_q;

    hs      = cmd_valid_q & command_ready;
    rsp_ok  = response_valid & (out_q != 2'd0);
    acc_sum = acc_q + {4'd0, response_data};

    // In-flight count; a beat with nothing outstanding is an anomaly, not a decrement.
    case ({hs, rsp_ok})
      2'b10:   out_d = out_q + 2'd1;
      2'b01:   out_d = out_q - 2'd1;
      default: out_d = out_q;
    endcase
    if (response_valid && out_q == 2'd0) seq_err_d = 1'b1;

    if (rsp_ok) begin
      acc_d = acc_sum;
      if (response_channel != rsp_ch_q) seq_err_d = 1'b1;
      if (rsp_cnt_q == CNT_LAST) begin
        rsp_cnt_d        = '0;
        acc_d            = '0;
        result_valid_d   = 1'b1;
        result_data_d    = 12'(acc_sum >> AVG_LOG2);
        result_channel_d = rsp_ch_q;
        result_last_d    = (rsp_ch_q == last_q);
        rsp_ch_d         = (rsp_ch_q == last_q) ? first_q : rsp_ch_q + 5'd1;
      end else begin
        rsp_cnt_d = rsp_cnt_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (chan_first <= chan_last) begin
            first_d     = chan_first;
            last_d      = chan_last;
            cont_d      = cont;
            stop_pend_d = 1'b0;
            seq_err_d   = 1'b0;
            iss_ch_d    = chan_first;
            rsp_ch_d    = chan_first;
            iss_cnt_d   = '0;
            rsp_cnt_d   = '0;
            acc_d       = '0;
            state_d     = ISSUE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (stop) stop_pend_d = 1'b1;
        if (hs) begin
          if (iss_cnt_q == CNT_LAST) begin
            // Group boundary: a pending stop ends the scan here.
            iss_cnt_d = '0;
            if (stop_pend_d)            state_d  = DRAIN;
            else if (iss_ch_q == last_q) begin
              if (cont_q)               iss_ch_d = first_q;
              else                      state_d  = DRAIN;
            end else                    iss_ch_d = iss_ch_q + 5'd1;
          end else begin
            iss_cnt_d = iss_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // The final result pulse is already on the output when out_q hits 0.
        if (out_q == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Valid only rises while below the in-flight limit; since out_d never
    // grows without a handshake, an asserted command stays put until taken.
    cmd_valid_d   = (state_d == ISSUE) && (out_d < MAX_OUTL);
    cmd_channel_d = iss_ch_d;
    cmd_pkt_d     = cmd_valid_d;
    busy_d        = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q          <= IDLE;
      first_q          <= '0;
      last_q           <= '0;
      cont_q           <= 1'b0;
      stop_pend_q      <= 1'b0;
      iss_ch_q         <= '0;
      iss_cnt_q        <= '0;
      rsp_ch_q         <= '0;
      rsp_cnt_q        <= '0;
      out_q            <= '0;
      acc_q            <= '0;
      cmd_valid_q      <= 1'b0;
      cmd_channel_q    <= '0;
      cmd_pkt_q        <= 1'b0;
      result_valid_q   <= 1'b0;
      result_channel_q <= '0;
      result_data_q    <= '0;
      result_last_q    <= 1'b0;
      busy_q           <= 1'b0;
      seq_err_q        <= 1'b0;
      cfg_err_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      first_q          <= first_d;
      last_q           <= last_d;
      cont_q           <= cont_d;
      stop_pend_q      <= stop_pend_d;
      iss_ch_q         <= iss_ch_d;
      iss_cnt_q        <= iss_cnt_d;
      rsp_ch_q         <= rsp_ch_d;
      rsp_cnt_q        <= rsp_cnt_d;
      out_q            <= out_d;
      acc_q            <= acc_d;
      cmd_valid_q      <= cmd_valid_d;
      cmd_channel_q    <= cmd_channel_d;
      cmd_pkt_q        <= cmd_pkt_d;
      result_valid_q   <= result_valid_d;
      result_channel_q <= result_channel_d;
      result_data_q    <= result_data_d;
      result_last_q    <= result_last_d;
      busy_q           <= busy_d;
      seq_err_q        <= seq_err_d;
      cfg_err_q        <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a latency-programmable ADC model.
module tb_adc_scan_sequencer;

  localparam int MAX_OUT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, cont = 1'b0;
  logic [4:0]  chan_first = '0, chan_last = '0;
  logic        command_valid, command_startofpacket, command_endofpacket;
  logic [4:0]  command_channel;
  logic        command_ready = 1'b1;
  logic        response_valid = 1'b0;
  logic [4:0]  response_channel = '0;
  logic [11:0] response_data = '0;
  logic        response_startofpacket = 1'b0, response_endofpacket = 1'b0;
  logic        result_valid, result_last, busy, seq_err, cfg_err;
  logic [4:0]  result_channel;
  logic [11:0] result_data;

  adc_scan_sequencer #(.AVG_LOG2(2), .MAX_OUT(MAX_OUT)) dut (
    .clock_clk(clk), .reset_sink_reset_n(rst_n),
    .start(start), .stop(stop), .chan_first(chan_first), .chan_last(chan_last), .cont(cont),
    .command_valid(command_valid), .command_channel(command_channel),
    .command_startofpacket(command_startofpacket), .command_endofpacket(command_endofpacket),
    .command_ready(command_ready),
    .response_valid(response_valid), .response_channel(response_channel),
    .response_data(response_data),
    .response_startofpacket(response_startofpacket), .response_endofpacket(response_endofpacket),
    .result_valid(result_valid), .result_channel(result_channel), .result_data(result_data),
    .result_last(result_last), .busy(busy), .seq_err(seq_err), .cfg_err(cfg_err)
  );

  always #10 clk = ~clk;

  typedef struct packed { logic [4:0] ch; logic [11:0] data; logic last; } res_t;
  typedef struct { logic [4:0] ch; int due; } cmd_t;

  // Model state, owned by the ADC process below.
  cmd_t       cmdq[$];
  res_t       resq[$];
  logic [4:0] hs_ch[$];
  int hs_n = 0, resp_n = 0, max_seen = 0, viol = 0, cyc = 0;
  int clr_done = 0, stray_done = 0, corrupt_done = 0;
  // Requests from the stimulus process.
  int clr_req = 0, stray_req = 0, corrupt_req = 0, lat = 3, mode = 0;

  int checks = 0, errors = 0;

  // ADC model and output monitor; runs mid-low-phase after stimulus settles.
  always @(negedge clk) begin
    cmd_t c;
    #4;
    cyc++;
    if (clr_req != clr_done) begin
      cmdq.delete(); resq.delete(); hs_ch.delete();
      hs_n = 0; resp_n = 0; max_seen = 0; viol = 0; clr_done = clr_req;
    end
    response_valid = 1'b0; response_channel = '0; response_data = '0;
    if (rst_n) begin
      if (cmdq.size() > max_seen) max_seen = cmdq.size();
      if (command_valid && cmdq.size() >= MAX_OUT) viol++;
      if (result_valid) resq.push_back('{result_channel, result_data, result_last});
      if (stray_req != stray_done) begin
        response_valid = 1'b1; stray_done = stray_req;
      end else if (cmdq.size() > 0 && cmdq[0].due <= cyc) begin
        c = cmdq.pop_front();
        response_valid   = 1'b1;
        response_channel = c.ch;
        if (corrupt_req != corrupt_done) begin
          response_channel = c.ch ^ 5'd1; corrupt_done = corrupt_req;
        end
        response_data = 12'(int'(c.ch) * 100 + ((mode != 0) ? (resp_n % 4) : 0));
        resp_n++;
      end
      if (command_valid && command_ready) begin
        c.ch = command_channel; c.due = cyc + lat;
        cmdq.push_back(c); hs_ch.push_back(command_channel); hs_n++;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_res(input int idx, input logic [4:0] ch, input logic [11:0] d, input logic l);
    res_t r;
    r = (resq.size() > idx) ? resq[idx] : '0;
    chk($sformatf("result%0d", idx), {14'd0, r}, {14'd0, ch, d, l});
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (busy !== 1'b0 && n < maxc) begin tick(); n++; end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_hs(input int target, input int maxc);
    int n = 0;
    while (hs_n < target && n < maxc) begin tick(); n++; end
    chk("hs_timeout", (hs_n >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic scan(input logic [4:0] f, input logic [4:0] l, input logic c);
    chan_first = f; chan_last = l; cont = c; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] all_out();
    return {2'd0, command_valid, command_channel, command_startofpacket, command_endofpacket,
            result_valid, result_channel, result_data, result_last, busy, seq_err, cfg_err};
  endfunction

  initial begin
    int n2;
    // Reset state
    tick(); tick();
    chk("reset_outputs", all_out(), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Basic single scan 3..4, constant samples
    lat = 3; mode = 0; clr_req++; tick();
    scan(5'd3, 5'd4, 1'b0);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    chk("basic_cmd", {26'd0, command_valid, command_channel}, {26'd0, 1'b1, 5'd3});
    chk("basic_pkt", {30'd0, command_startofpacket, command_endofpacket}, 32'd3);
    wait_idle(200);
    chk("basic_nres", resq.size(), 32'd2);
    chk_res(0, 5'd3, 12'd300, 1'b0);
    chk_res(1, 5'd4, 12'd400, 1'b1);
    chk("basic_hs", hs_n, 32'd8);
    chk("basic_seq_err", {31'd0, seq_err}, 32'd0);

    // Long latency: in-flight limit, truncating average (500..503 -> 501)
    lat = 10; mode = 1; clr_req++; tick();
    scan(5'd5, 5'd5, 1'b0);
    wait_idle(300);
    chk("lat_max_out", max_seen, 32'd2);
    chk("lat_valid_at_max", viol, 32'd0);
    chk("lat_nres", resq.size(), 32'd1);
    chk_res(0, 5'd5, 12'd501, 1'b1);

    // Backpressure: command held stable, exactly one handshake per ready cycle
    lat = 2; mode = 0; command_ready = 1'b0; clr_req++; tick();
    scan(5'd2, 5'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {26'd0, command_valid, command_channel}, {26'd0, 1'b1, 5'd2});
      tick();
    end
    chk("bp_no_hs", hs_n, 32'd0);
    command_ready = 1'b1; tick();
    command_ready = 1'b0; tick();
    chk("bp_one_hs", hs_n, 32'd1);
    command_ready = 1'b1;
    wait_idle(200);
    chk("bp_total_hs", hs_n, 32'd4);
    chk_res(0, 5'd2, 12'd200, 1'b1);

    // Continuous 1..2, stop during second channel-1 group
    lat = 2; clr_req++; tick();
    scan(5'd1, 5'd2, 1'b1);
    wait_hs(9, 200);
    stop = 1'b1; tick();
    stop = 1'b0;
    wait_idle(300);
    n2 = 0;
    foreach (hs_ch[i]) if (hs_ch[i] == 5'd2) n2++;
    chk("stop_hs", hs_n, 32'd12);
    chk("stop_ch2_cmds", n2, 32'd4);
    chk("stop_last_ch", {27'd0, hs_ch[hs_ch.size()-1]}, 32'd1);
    chk("stop_nres", resq.size(), 32'd3);
    chk_res(1, 5'd2, 12'd200, 1'b1);
    chk_res(2, 5'd1, 12'd100, 1'b0);

    // Illegal range
    clr_req++; tick();
    scan(5'd7, 5'd5, 1'b0);
    chk("cfg_err_pulse", {30'd0, cfg_err, busy}, 32'd2);
    tick();
    chk("cfg_err_clear", {30'd0, cfg_err, busy}, 32'd0);
    chk("cfg_no_hs", hs_n, 32'd0);

    // Corrupted response channel: sticky seq_err, sample still averaged
    corrupt_req++; clr_req++; tick();
    scan(5'd6, 5'd6, 1'b0);
    wait_idle(200);
    chk_res(0, 5'd6, 12'd600, 1'b1);
    tick(); tick();
    chk("seq_err_sticky", {31'd0, seq_err}, 32'd1);
    scan(5'd6, 5'd6, 1'b0);
    chk("seq_err_cleared", {31'd0, seq_err}, 32'd0);
    wait_idle(200);
    chk("seq_err_clean", {31'd0, seq_err}, 32'd0);

    // Reset with two commands outstanding
    lat = 10; clr_req++; tick();
    scan(5'd8, 5'd9, 1'b0);
    wait_hs(2, 50);
    rst_n = 1'b0; #1;
    chk("midreset_outputs", all_out(), 32'd0);
    tick(); tick();
    clr_req++; tick();
    rst_n = 1'b1; tick();
    stray_req++; tick(); tick();
    chk("stray_seq_err", {31'd0, seq_err}, 32'd1);
    lat = 3; mode = 1; clr_req++; tick();
    scan(5'd8, 5'd9, 1'b0);
    wait_idle(200);
    chk("post_reset_nres", resq.size(), 32'd2);
    chk_res(0, 5'd8, 12'd801, 1'b0);
    chk_res(1, 5'd9, 12'd901, 1'b1);
    chk("post_reset_seq_err", {31'd0, seq_err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter AVG_LOG2, default 2: log2 of the number of samples averaged per channel (legal 0..4).
REQ-002 Parameter MAX_OUT, default 2: maximum number of commands accepted by the ADC but not yet answered (legal 1..3).
REQ-003 clock_clk  in  1  sole clock; all logic is rising-edge.
REQ-004 reset_sink_reset_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle pulse that begins a scan; ignored while busy=1.
REQ-006 stop  in  1  one-cycle pulse that requests the end of a continuous scan.
REQ-007 chan_first / chan_last  in  5 each  inclusive channel range, sampled on start.
REQ-008 cont  in  1  sampled on start; 1 = continuous scan.
REQ-009 command_valid  out  1  ADC command valid.
REQ-010 command_channel  out  5  ADC command channel.
REQ-011 command_startofpacket / command_endofpacket  out  1 each  packet delimiters.
REQ-012 command_ready  in  1  ADC accepts the command beat.
REQ-013 response_valid  in  1  ADC response beat valid.
REQ-014 response_channel  in  5  channel of the response beat.
REQ-015 response_data  in  12  ADC sample.
REQ-016 response_startofpacket / response_endofpacket  in  1 each  packet delimiters; ignored by this block.
REQ-017 result_valid  out  1  one-cycle pulse: averaged result available.
REQ-018 result_channel  out  5  channel of the averaged result.
REQ-019 result_data  out  12  averaged sample.
REQ-020 result_last  out  1  1 with result_valid when the result is for chan_last.
REQ-021 busy  out  1  scan in progress.
REQ-022 seq_err  out  1  sticky: response anomaly.
REQ-023 cfg_err  out  1  one-cycle pulse: start rejected because of an illegal range.

Function
REQ-024 States: IDLE, ISSUE, DRAIN. busy=1 in ISSUE and DRAIN.
REQ-025 IDLE, start with chan_first<=chan_last: latch the configuration, clear seq_err, set the issue and response channel pointers to chan_first and both sample counters to 0, go to ISSUE.
REQ-026 IDLE, start with chan_first>chan_last: pulse cfg_err for one cycle; state stays IDLE.
REQ-027 ISSUE: command_valid=1 while outstanding<MAX_OUT, with command_channel equal to the issue pointer and command_startofpacket=command_endofpacket=1.
REQ-028 Once asserted, command_valid and command_channel hold stable until the cycle in which command_ready=1 (the handshake).
REQ-029 Each handshake increments the issue sample counter; after 2^AVG_LOG2 handshakes for one channel, the counter resets and the issue pointer advances by 1.
REQ-030 After the chan_last group is fully issued: if cont=1 and no stop is pending, the issue pointer wraps to chan_first; otherwise go to DRAIN.
REQ-031 stop in ISSUE sets a stop-pending flag; the current channel group is still issued in full, then the block goes to DRAIN; stop is ignored in IDLE.
REQ-032 outstanding counter: +1 on a handshake, -1 on a response_valid beat; a handshake and a response in the same cycle leave it unchanged.
REQ-033 Each response beat adds zero-extended response_data to a 16-bit accumulator; response-side pointer and counter advance exactly as on the issue side.
REQ-034 After the 2^AVG_LOG2-th response of a group, on the next cycle: result_valid=1; result_data=accumulator>>AVG_LOG2 (truncating); result_channel=response pointer before advance; result_last set per REQ-020. The accumulator then clears.
REQ-035 response_channel differing from the response pointer sets seq_err; the sample is still accumulated.
REQ-036 response_valid with outstanding=0 sets seq_err; the beat is otherwise ignored and the counter does not underflow.
REQ-037 DRAIN: command_valid=0; go to IDLE in the cycle after outstanding reaches 0 and the final result pulse has been issued.
REQ-038 There is no result backpressure; result_valid is a single-cycle pulse.

Reset
REQ-039 While reset_sink_reset_n=0, all state clears asynchronously: state=IDLE, and command_valid, command_channel, command_startofpacket, command_endofpacket, result_valid, result_channel, result_data, result_last, busy, seq_err and cfg_err are all 0.
REQ-040 Reset mid-operation discards any in-flight commands and accumulators; responses arriving after reset while in IDLE set seq_err per REQ-036.

Verification
REQ-041 chan 3..4, cont=0, AVG_LOG2=2, ready always 1, each response=channel*100 -> results (3,300,last=0), (4,400,last=1); busy falls; seq_err=0.
REQ-042 command_ready held 0 for 5 cycles -> command_valid and command_channel stay stable throughout; exactly one handshake occurs when ready rises.
REQ-043 ADC response latency 10 cycles -> outstanding never exceeds MAX_OUT=2; no command_valid while outstanding=2.
REQ-044 cont=1, chan 1..2, stop during the second channel-1 group -> that group completes; no channel-2 command is issued afterwards; block returns to IDLE.
REQ-045 start with first=7, last=5 -> single-cycle cfg_err, busy stays 0; response_channel corrupted once -> seq_err=1 until the next start.
REQ-046 Reset asserted with 2 commands outstanding -> all outputs 0 immediately; the next scan produces correct averages.
